// File: rtl/spi_main_if.sv
// spi_main_if: bundles the host-side handshake and the SPI pin signals of spi_main.
//   start, data_word_to_send : transfer request and the word to send
//   busy, word_done          : transfer status and 1-cycle completion pulse
//   data_word_received       : last complete received word
//   sck, cs_n, out_bit       : SPI clock, chip select, MOSI
//   in_bit                   : MISO
// The master modport is for the side that requests transfers and drives MISO
// (a host plus the pin environment, e.g. a testbench). The slave modport is
// for spi_main itself.
interface spi_main_if #(
  parameter int WORD_BITS = 8
);
  logic                 start;
  logic [WORD_BITS-1:0] data_word_to_send;
  logic                 busy;
  logic                 word_done;
  logic [WORD_BITS-1:0] data_word_received;
  logic                 sck;
  logic                 cs_n;
  logic                 out_bit;
  logic                 in_bit;

  modport master (
    output start, data_word_to_send, in_bit,
    input  busy, word_done, data_word_received, sck, cs_n, out_bit
  );

  modport slave (
    input  start, data_word_to_send, in_bit,
    output busy, word_done, data_word_received, sck, cs_n, out_bit
  );
endinterface

// File: rtl/spi_main.sv
// spi_main: SPI controller, mode 0, MSB first, full duplex, one WORD_BITS word
// per accepted start request.
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset, aborts any transfer
//   bus   : spi_main_if.slave (start/data in, busy/word_done/received out,
//           sck/cs_n/out_bit pins out, in_bit pin in)
// Every output comes straight from a register. A transfer is SETUP, then
// WORD_BITS x (HIGH, LOW) with the last LOW replaced by HOLD, each phase
// CLK_DIV cycles long; completion is folded into the transition back to IDLE.
module spi_main #(
  parameter int WORD_BITS = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_main_if.slave bus
);
  localparam int HW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [HW-1:0]        half_cnt_reg, half_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [WORD_BITS-1:0] tx_reg, tx_next;
  logic [WORD_BITS-1:0] rx_reg, rx_next;
  logic [WORD_BITS-1:0] rx_word_reg, rx_word_next;
  logic                 sck_reg, sck_next;
  logic                 cs_n_reg, cs_n_next;
  logic                 out_bit_reg, out_bit_next;
  logic                 busy_reg, busy_next;
  logic                 word_done_reg, word_done_next;

  logic half_last;
  assign half_last = (half_cnt_reg == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      half_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      rx_word_reg   <= '0;
      sck_reg       <= 1'b0;
      cs_n_reg      <= 1'b1;
      out_bit_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      word_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      half_cnt_reg  <= half_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      rx_word_reg   <= rx_word_next;
      sck_reg       <= sck_next;
      cs_n_reg      <= cs_n_next;
      out_bit_reg   <= out_bit_next;
      busy_reg      <= busy_next;
      word_done_reg <= word_done_next;
    end
  end

  // Next-state logic computes the registered output values for the cycle after
  // the edge, so each output changes exactly on the state transition.
  always_comb begin
    state_next     = state_reg;
    half_cnt_next  = half_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    rx_word_next   = rx_word_reg;
    sck_next       = sck_reg;
    cs_n_next      = cs_n_reg;
    out_bit_next   = out_bit_reg;
    busy_next      = busy_reg;
    word_done_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next    = SETUP;
          tx_next       = bus.data_word_to_send;
          rx_next       = '0;
          half_cnt_next = '0;
          bit_cnt_next  = '0;
          cs_n_next     = 1'b0;
          busy_next     = 1'b1;
          out_bit_next  = bus.data_word_to_send[WORD_BITS-1];
        end
      end
      SETUP: begin
        if (half_last) begin
          state_next    = HIGH;
          half_cnt_next = '0;
          sck_next      = 1'b1;
        end else begin
          half_cnt_next = half_cnt_reg + 1'b1;
        end
      end
      HIGH: begin
        if (half_last) begin
          // Last cycle before the falling edge: sample MISO, then present the
          // next MOSI bit together with the falling edge.
          rx_next       = {rx_reg[WORD_BITS-2:0], bus.in_bit};
          half_cnt_next = '0;
          sck_next      = 1'b0;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = HOLD;
          end else begin
            state_next   = LOW;
            tx_next      = {tx_reg[WORD_BITS-2:0], 1'b0};
            out_bit_next = tx_reg[WORD_BITS-2];
          end
        end else begin
          half_cnt_next = half_cnt_reg + 1'b1;
        end
      end
      LOW: begin
        if (half_last) begin
          state_next    = HIGH;
          half_cnt_next = '0;
          bit_cnt_next  = bit_cnt_reg + 1'b1;
          sck_next      = 1'b1;
        end else begin
          half_cnt_next = half_cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (half_last) begin
          // Completion cycle merged into IDLE entry: busy drops the same cycle
          // word_done pulses, so a start held high is accepted right away.
          state_next     = IDLE;
          half_cnt_next  = '0;
          bit_cnt_next   = '0;
          cs_n_next      = 1'b1;
          busy_next      = 1'b0;
          out_bit_next   = 1'b0;
          word_done_next = 1'b1;
          rx_word_next   = rx_reg;
        end else begin
          half_cnt_next = half_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sck                = sck_reg;
  assign bus.cs_n               = cs_n_reg;
  assign bus.out_bit            = out_bit_reg;
  assign bus.busy               = busy_reg;
  assign bus.word_done          = word_done_reg;
  assign bus.data_word_received = rx_word_reg;
endmodule

// File: tb/tb_spi_main.sv
module tb_spi_main;
  // Edges from the accepting edge to the edge that raises word_done:
  // CLK_DIV*(2*WORD_BITS+1), i.e. word_done "at cycle 69" with busy from cycle 1.
  localparam int LAT8  = 4 * (2 * 8 + 1);
  localparam int LAT16 = 6 * (2 * 16 + 1);

  // in_bit source selection
  localparam logic [1:0] M_LOOP = 2'd0, M_ONE = 2'd1, M_ZERO = 2'd2, M_SEC = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_main_if #(.WORD_BITS(8))  bus ();
  spi_main_if #(.WORD_BITS(16)) bus2 ();

  spi_main #(.WORD_BITS(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  spi_main #(.WORD_BITS(16), .CLK_DIV(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // ---------------- pin environment ----------------
  logic [1:0] mode = M_LOOP;

  // Mode-0 secondary model: preloads 0x3C on cs_n fall, shifts MISO after each
  // sck falling edge, samples MOSI on each sck rising edge.
  logic [7:0] sec_tx = 8'h00, sec_rx = 8'h00;
  logic       cs_d = 1'b1, sck_d = 1'b0;
  always @(posedge clk) begin
    cs_d  <= bus.cs_n;
    sck_d <= bus.sck;
    if (cs_d && !bus.cs_n)      sec_tx <= 8'h3C;
    else if (sck_d && !bus.sck) sec_tx <= {sec_tx[6:0], 1'b0};
    if (!sck_d && bus.sck)      sec_rx <= {sec_rx[6:0], bus.out_bit};
  end

  assign bus.in_bit = (mode == M_LOOP) ? bus.out_bit :
                      (mode == M_ONE)  ? 1'b1 :
                      (mode == M_ZERO) ? 1'b0 : sec_tx[7];
  assign bus2.in_bit = 1'b1;

  // MOSI as seen at each sck rising edge, and the total rising-edge count.
  logic [7:0] mosi_sh = 8'h00;
  int         sck_total = 0;
  always @(posedge bus.sck) begin
    mosi_sh   <= {mosi_sh[6:0], bus.out_bit};
    sck_total <= sck_total + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    logic [7:0] exp;
    logic [1:0] mode;
    int         acc;
    int         sck_base;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    if (bus.word_done) begin
      if (q.size() == 0) begin
        chk("unexpected_word_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rx_word", {24'd0, bus.data_word_received}, {24'd0, e.exp});
        chk("latency", cyc - e.acc, LAT8);
        chk("sck_rises", sck_total - e.sck_base, 32'd8);
        chk("mosi_seq", {24'd0, mosi_sh}, {24'd0, e.data});
        chk("cs_n_at_done", {31'd0, bus.cs_n}, 32'd1);
        if (e.mode == M_SEC) chk("secondary_rx", {24'd0, sec_rx}, {24'd0, e.data});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_q_empty();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("word_done_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  // Drive one start pulse from idle and queue its expectation.
  task automatic xfer_begin(input logic [7:0] d, input logic [1:0] m, input logic [7:0] exp);
    exp_t e;
    wait_idle();
    mode = m;
    bus.data_word_to_send = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.data = d; e.exp = exp; e.mode = m; e.acc = cyc; e.sck_base = sck_total;
    q.push_back(e);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, M_LOOP, 8'hA5};
    vecs[1] = '{8'hC3, M_SEC,  8'h3C};
    vecs[2] = '{8'h00, M_ONE,  8'hFF};
    vecs[3] = '{8'hFF, M_ZERO, 8'h00};
    vecs[4] = '{8'h01, M_LOOP, 8'h01};
    vecs[5] = '{8'h80, M_LOOP, 8'h80};

    bus.start = 1'b0;
    bus.data_word_to_send = 8'h00;
    bus2.start = 1'b0;
    bus2.data_word_to_send = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sck", {31'd0, bus.sck}, 32'd0);
    chk("rst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_word_done", {31'd0, bus.word_done}, 32'd0);
    chk("rst_out_bit", {31'd0, bus.out_bit}, 32'd0);
    chk("rst_rx", {24'd0, bus.data_word_received}, 32'd0);
    rst_n = 1'b1;

    // Table-driven single transfers
    for (int i = 0; i < 6; i++) begin
      xfer_begin(vecs[i].data, vecs[i].mode, vecs[i].exp);
      @(negedge clk);
      chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
      wait_q_empty();
      @(negedge clk);
      chk("out_bit_idle", {31'd0, bus.out_bit}, 32'd0);
    end

    // Start during a transfer with different data is ignored
    xfer_begin(8'h96, M_LOOP, 8'h96);
    repeat (19) @(negedge clk);
    bus.data_word_to_send = 8'h69;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_q_empty();
    repeat (80) @(negedge clk);
    chk("no_extra_busy", {31'd0, bus.busy}, 32'd0);

    // Start held high: back-to-back transfers, accepted every 69 edges
    begin
      int acc0, base0, hi;
      exp_t e;
      wait_idle();
      mode = M_LOOP;
      bus.data_word_to_send = 8'h5A;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      acc0 = cyc;
      base0 = sck_total;
      for (int k = 0; k < 3; k++) begin
        e.data = 8'h5A; e.exp = 8'h5A; e.mode = M_LOOP;
        e.acc = acc0 + k * (LAT8 + 1); e.sck_base = base0 + 8 * k;
        q.push_back(e);
      end
      hi = 0;
      for (int i = 1; i <= 206; i++) begin
        @(negedge clk);
        if (bus.cs_n) hi++;
        if (i == 200) bus.start = 1'b0;
      end
      chk("b2b_cs_n_high_cycles", hi, 32'd2);
      wait_q_empty();
    end

    // Asynchronous reset mid-transfer
    xfer_begin(8'h3C, M_LOOP, 8'h3C);
    repeat (29) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("abort_sck", {31'd0, bus.sck}, 32'd0);
    chk("abort_cs_n", {31'd0, bus.cs_n}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_rx_cleared", {24'd0, bus.data_word_received}, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", {31'd0, bus.word_done}, 32'd0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    xfer_begin(8'h7E, M_LOOP, 8'h7E);
    wait_q_empty();

    // Wide/slow instance: WORD_BITS=16, CLK_DIV=6, in_bit tied high
    begin
      int acc2, n;
      @(negedge clk);
      bus2.data_word_to_send = 16'h1234;
      bus2.start = 1'b1;
      @(posedge clk);
      #1;
      bus2.start = 1'b0;
      acc2 = cyc;
      n = 0;
      @(negedge clk);
      while (!bus2.word_done && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!bus2.word_done) begin
        chk("w16_timeout", 32'd1, 32'd0);
      end else begin
        chk("w16_latency", cyc - acc2, LAT16);
        chk("w16_rx", {16'd0, bus2.data_word_received}, 32'h0000FFFF);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
